// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - dreq_info encoding, size/state enums and alignment helper
// Shared with the control unit so both sides agree on the dreq_info layout.
package mem_access_unit_pkg;

  localparam int XLEN              = 64;
  localparam int BYTES             = XLEN / 8;
  localparam int INFO_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } memu_state_t;

  function automatic logic is_misaligned(input msize_t size, input logic [2:0] off);
    case (size)
      MSIZE_H: return off[0];
      MSIZE_W: return off[1:0] != 2'b00;
      MSIZE_D: return off != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// rtl/mem_access_unit_align.sv - byte-lane steering for stores, extract/extend for loads
// Purely combinational; the offset is the low three address bits.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  msize_t             size,
  input  logic               is_unsigned,
  input  logic               is_store,
  input  logic [2:0]         off,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN-1:0]    rword,
  output logic [BYTES-1:0]   strobe,
  output logic [XLEN-1:0]    sdata,
  output logic [XLEN-1:0]    ldata
);

  logic [BYTES-1:0] base_mask;
  logic [XLEN-1:0]  sh;

  always_comb begin
    base_mask = 8'h01;
    ldata     = '0;
    case (size)
      MSIZE_B: base_mask = 8'h01;
      MSIZE_H: base_mask = 8'h03;
      MSIZE_W: base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase

    strobe = is_store ? (base_mask << off) : '0;
    sdata  = wdata << {off, 3'b000};
    sh     = rword >> {off, 3'b000};

    case (size)
      MSIZE_B: ldata = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      MSIZE_H: ldata = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      MSIZE_W: ldata = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ldata = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: one aligned bus transaction per start pulse
// Latches the request on accept, drives the bus from latched fields, pulses memu_finish once.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memu_valid,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [2:0]        dreq_info,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [BYTES-1:0]  dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              memu_finish,
  output logic [XLEN-1:0]   rdata,
  output logic              misalign_err
);

  memu_state_t     state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  msize_t          size_q, size_d;
  logic            uns_q, uns_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] ldata;
  logic            accept_mis;

  assign accept_mis = is_misaligned(msize_t'(dreq_info[1:0]), addr[2:0]);

  mem_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .is_store    (we_q),
    .off         (addr_q[2:0]),
    .wdata       (wdata_q),
    .rword       (dresp_data),
    .strobe      (dreq_strobe),
    .sdata       (dreq_data),
    .ldata       (ldata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (memu_valid && (dm_re || dm_we)) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = msize_t'(dreq_info[1:0]);
          uns_d   = dreq_info[INFO_UNSIGNED_BIT];
          we_d    = dm_we;
          err_d   = accept_mis;
          if (accept_mis) begin
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            state_d = S_DONE;
            if (!we_q) rdata_d = ldata;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (dresp_data_ok) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = ldata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= MSIZE_B;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dreq_valid   = (state_q == S_REQ);
  assign dreq_addr    = addr_q;
  assign dreq_size    = size_q;
  assign memu_finish  = (state_q == S_DONE);
  assign rdata        = rdata_q;
  assign misalign_err = err_q;

  // A completion before the request was accepted means the bus broke protocol.
  a_no_early_data: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_REQ && dresp_data_ok) |-> dresp_addr_ok);

endmodule
